// File: rtl/lines_pkg.sv
// lines_pkg
// Shared constants and helpers for the debounced BCD line front end.
//   LINES_*        : default parameter values for lines_debounced
//   lines_cnt_width: width of the per-channel stability counter

package lines_pkg;

    localparam int LINES_WIDTH         = 4;
    localparam int LINES_CHANNELS      = 4;
    localparam int LINES_MAX_VAL       = 9;
    localparam int LINES_SYNC_STAGES   = 2;
    localparam int LINES_STABLE_CYCLES = 16;

    // Counter must hold STABLE_CYCLES-1.
    // It stays at least one bit wide even when STABLE_CYCLES is 1.
    function automatic int lines_cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage : lines_pkg

// File: rtl/lines_debounce_ch.sv
// lines_debounce_ch
// One channel: input synchroniser, whole-vector debouncer, commit register,
// change strobe and out-of-range flag.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   din_i     : raw asynchronous lines for this digit
//   hold_i    : freeze dout_o/err_o (synchronous)
//   dout_o    : committed debounced value (registered)
//   changed_o : one-cycle pulse when dout_o takes a new value
//   err_o     : committed value > MAX_VAL (registered)

module lines_debounce_ch
    import lines_pkg::*;
#(
    parameter int WIDTH         = LINES_WIDTH,
    parameter int SYNC_STAGES   = LINES_SYNC_STAGES,
    parameter int STABLE_CYCLES = LINES_STABLE_CYCLES,
    parameter int MAX_VAL       = LINES_MAX_VAL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din_i,
    input  logic             hold_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             changed_o,
    output logic             err_o
);

    localparam int CW = lines_cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
    localparam int unsigned MAX_U = MAX_VAL;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s;

    logic [WIDTH-1:0] cand_q, cand_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             changed_q, changed_d;
    logic             err_q, err_d;
    logic             commit;

    // Synchroniser chain. Stage 0 samples the raw asynchronous lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= din_i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // The commit decision uses the current (pre-edge) counter and candidate.
    // A bounce arriving on this edge (s != cand) therefore blocks the commit.
    assign commit = (cnt_q == CNT_MAX) && (s == cand_q) &&
                    (cand_q != dout_q) && !hold_i;

    always_comb begin
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        dout_d    = dout_q;
        err_d     = err_q;
        changed_d = 1'b0;

        if (s != cand_q) begin
            cand_d = s;
            cnt_d  = '0;
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (commit) begin
            dout_d    = cand_q;
            changed_d = 1'b1;
            err_d     = (32'(cand_q) > MAX_U);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q    <= '0;
            cnt_q     <= '0;
            dout_q    <= '0;
            changed_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            dout_q    <= dout_d;
            changed_q <= changed_d;
            err_q     <= err_d;
        end
    end

    assign dout_o    = dout_q;
    assign changed_o = changed_q;
    assign err_o     = err_q;

endmodule : lines_debounce_ch

// File: rtl/lines_debounced.sv
// lines_debounced
// CHANNELS independent debounced BCD digit groups feeding the 7-segment decoders.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   din     : raw lines, channel i = din[i*WIDTH +: WIDTH]
//   hold    : per-channel freeze of dout/err
//   dout    : committed debounced value per channel
//   changed : per-channel one-cycle pulse on a new committed value
//   err     : per-channel committed value > MAX_VAL

module lines_debounced
    import lines_pkg::*;
#(
    parameter int WIDTH         = LINES_WIDTH,
    parameter int CHANNELS      = LINES_CHANNELS,
    parameter int SYNC_STAGES   = LINES_SYNC_STAGES,
    parameter int STABLE_CYCLES = LINES_STABLE_CYCLES,
    parameter int MAX_VAL       = LINES_MAX_VAL
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic [CHANNELS-1:0]       hold,
    output logic [CHANNELS*WIDTH-1:0] dout,
    output logic [CHANNELS-1:0]       changed,
    output logic [CHANNELS-1:0]       err
);

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        lines_debounce_ch #(
            .WIDTH        (WIDTH),
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_CYCLES(STABLE_CYCLES),
            .MAX_VAL      (MAX_VAL)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .din_i    (din[gi*WIDTH +: WIDTH]),
            .hold_i   (hold[gi]),
            .dout_o   (dout[gi*WIDTH +: WIDTH]),
            .changed_o(changed[gi]),
            .err_o    (err[gi])
        );
    end

endmodule : lines_debounced

// File: tb/tb_lines_debounced.sv
module tb_lines_debounced;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic        rst_n;
    logic [15:0] din;
    logic [3:0]  hold;
    logic [15:0] dout;
    logic [3:0]  changed;
    logic [3:0]  err;

    // Fast instance: 2 channels, STABLE_CYCLES=1
    logic        rst_b_n;
    logic [7:0]  din_b;
    logic [1:0]  hold_b;
    logic [7:0]  dout_b;
    logic [1:0]  changed_b;
    logic [1:0]  err_b;

    int n_cmp = 0;
    int n_err = 0;

    lines_debounced u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (din),
        .hold   (hold),
        .dout   (dout),
        .changed(changed),
        .err    (err)
    );

    lines_debounced #(
        .WIDTH        (4),
        .CHANNELS     (2),
        .SYNC_STAGES  (2),
        .STABLE_CYCLES(1),
        .MAX_VAL      (9)
    ) u_dut_b (
        .clk    (clk),
        .rst_n  (rst_b_n),
        .din    (din_b),
        .hold   (hold_b),
        .dout   (dout_b),
        .changed(changed_b),
        .err    (err_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset held, then released with 0x1234 stable: commit at edge 19.
    task automatic test_reset();
        rst_n = 1'b0; rst_b_n = 1'b0;
        din = 16'h1234; hold = 4'b0; din_b = 8'h00; hold_b = 2'b0;
        repeat (3) tick();
        n_cmp++;
        if (dout !== 16'h0 || changed !== 4'h0 || err !== 4'h0) begin
            n_err++;
            $display("FAIL reset_state: dout=%h changed=%b err=%b want 0/0/0", dout, changed, err);
        end
        n_cmp++;
        if (dout_b !== 8'h0 || changed_b !== 2'b0 || err_b !== 2'b0) begin
            n_err++;
            $display("FAIL reset_state_b: dout=%h changed=%b err=%b want 0/0/0", dout_b, changed_b, err_b);
        end
        rst_n = 1'b1; rst_b_n = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            tick();
            n_cmp++;
            if (k < 19) begin
                if (dout !== 16'h0 || changed !== 4'h0) begin
                    n_err++;
                    $display("FAIL reset_latency edge %0d: dout=%h changed=%b want 0000/0000", k, dout, changed);
                end
            end else if (dout !== 16'h1234 || changed !== 4'hF || err !== 4'h0) begin
                n_err++;
                $display("FAIL reset_commit: dout=%h changed=%b err=%b want 1234/1111/0000", dout, changed, err);
            end
        end
        tick();
        n_cmp++;
        if (changed !== 4'h0 || dout !== 16'h1234) begin
            n_err++;
            $display("FAIL reset_pulse_end: dout=%h changed=%b want 1234/0000", dout, changed);
        end
        $display("test_reset done: dout=%h", dout);
    endtask

    // ch0 bounces 5/4 every 3 cycles, then settles on 5.
    task automatic test_bounce();
        for (int j = 0; j < 10; j++) begin
            din[3:0] = (j % 2 == 0) ? 4'h5 : 4'h4;
            repeat (3) begin
                tick();
                n_cmp++;
                if (dout[3:0] !== 4'h4 || changed !== 4'h0) begin
                    n_err++;
                    $display("FAIL bounce_quiet seg %0d: dout0=%h changed=%b want 4/0000", j, dout[3:0], changed);
                end
            end
        end
        din[3:0] = 4'h5;
        for (int k = 1; k <= 19; k++) begin
            tick();
            n_cmp++;
            if (k < 19) begin
                if (dout[3:0] !== 4'h4 || changed !== 4'h0) begin
                    n_err++;
                    $display("FAIL bounce_wait edge %0d: dout0=%h changed=%b want 4/0000", k, dout[3:0], changed);
                end
            end else if (dout[3:0] !== 4'h5 || changed !== 4'b0001) begin
                n_err++;
                $display("FAIL bounce_commit: dout0=%h changed=%b want 5/0001", dout[3:0], changed);
            end
        end
        tick();
        n_cmp++;
        if (changed !== 4'h0) begin
            n_err++;
            $display("FAIL bounce_pulse_end: changed=%b want 0000", changed);
        end
        $display("test_bounce done: dout=%h", dout);
    endtask

    // Hold ch1 at 3 while din moves to 7; release commits next edge.
    task automatic test_hold();
        hold[1] = 1'b1;
        din[7:4] = 4'h7;
        for (int k = 1; k <= 40; k++) begin
            tick();
            n_cmp++;
            if (dout[7:4] !== 4'h3 || changed[1] !== 1'b0) begin
                n_err++;
                $display("FAIL hold_frozen edge %0d: dout1=%h changed1=%b want 3/0", k, dout[7:4], changed[1]);
            end
        end
        hold[1] = 1'b0;
        tick();
        n_cmp++;
        if (dout[7:4] !== 4'h7 || changed !== 4'b0010) begin
            n_err++;
            $display("FAIL hold_release: dout1=%h changed=%b want 7/0010", dout[7:4], changed);
        end
        tick();
        n_cmp++;
        if (changed !== 4'h0) begin
            n_err++;
            $display("FAIL hold_pulse_end: changed=%b want 0000", changed);
        end
        $display("test_hold done: dout=%h", dout);
    endtask

    // ch2 commits C (err=1), then 8 (err=0); err follows the commit edge.
    task automatic test_range();
        din[11:8] = 4'hC;
        for (int k = 1; k <= 19; k++) begin
            tick();
            if (k == 18) begin
                n_cmp++;
                if (dout[11:8] !== 4'h2 || err[2] !== 1'b0) begin
                    n_err++;
                    $display("FAIL range_pre_c: dout2=%h err2=%b want 2/0", dout[11:8], err[2]);
                end
            end
        end
        n_cmp++;
        if (dout[11:8] !== 4'hC || err !== 4'b0100 || changed !== 4'b0100) begin
            n_err++;
            $display("FAIL range_commit_c: dout2=%h err=%b changed=%b want C/0100/0100", dout[11:8], err, changed);
        end
        din[11:8] = 4'h8;
        for (int k = 1; k <= 19; k++) begin
            tick();
            if (k == 18) begin
                n_cmp++;
                if (err[2] !== 1'b1) begin
                    n_err++;
                    $display("FAIL range_err_held: err2=%b want 1", err[2]);
                end
            end
        end
        n_cmp++;
        if (dout[11:8] !== 4'h8 || err !== 4'b0000 || changed !== 4'b0100) begin
            n_err++;
            $display("FAIL range_commit_8: dout2=%h err=%b changed=%b want 8/0000/0100", dout[11:8], err, changed);
        end
        $display("test_range done: dout=%h err=%b", dout, err);
    endtask

    // ch3 commits 6, glitches to 2 for 5 cycles, returns to 6: no new commit.
    task automatic test_glitch();
        din[15:12] = 4'h6;
        repeat (19) tick();
        n_cmp++;
        if (dout[15:12] !== 4'h6 || changed !== 4'b1000) begin
            n_err++;
            $display("FAIL glitch_setup: dout3=%h changed=%b want 6/1000", dout[15:12], changed);
        end
        din[15:12] = 4'h2;
        repeat (5) tick();
        din[15:12] = 4'h6;
        for (int k = 1; k <= 40; k++) begin
            tick();
            n_cmp++;
            if (dout[15:12] !== 4'h6 || changed !== 4'h0) begin
                n_err++;
                $display("FAIL glitch_quiet edge %0d: dout3=%h changed=%b want 6/0000", k, dout[15:12], changed);
            end
        end
        $display("test_glitch done: dout=%h", dout);
    endtask

    // Reset asserted mid-debounce clears outputs asynchronously; stable
    // nonzero din re-commits only after full latency.
    task automatic test_reset_mid();
        din[11:8] = 4'hD;
        repeat (19) tick();
        n_cmp++;
        if (dout !== 16'h6D75 || err !== 4'b0100) begin
            n_err++;
            $display("FAIL mid_setup: dout=%h err=%b want 6D75/0100", dout, err);
        end
        din = 16'h1111;
        repeat (10) tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (dout !== 16'h0 || err !== 4'h0 || changed !== 4'h0) begin
            n_err++;
            $display("FAIL mid_async_clear: dout=%h err=%b changed=%b want 0/0/0", dout, err, changed);
        end
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            tick();
            n_cmp++;
            if (k < 19) begin
                if (dout !== 16'h0 || changed !== 4'h0) begin
                    n_err++;
                    $display("FAIL mid_latency edge %0d: dout=%h changed=%b want 0/0000", k, dout, changed);
                end
            end else if (dout !== 16'h1111 || changed !== 4'hF || err !== 4'h0) begin
                n_err++;
                $display("FAIL mid_recommit: dout=%h changed=%b err=%b want 1111/1111/0000", dout, changed, err);
            end
        end
        $display("test_reset_mid done: dout=%h", dout);
    endtask

    // STABLE_CYCLES=1 instance: commit at edge SYNC_STAGES+2 = 4.
    task automatic test_fast();
        din_b = 8'h37;
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_cmp++;
            if (k < 4) begin
                if (dout_b !== 8'h00 || changed_b !== 2'b00) begin
                    n_err++;
                    $display("FAIL fast_wait edge %0d: dout=%h changed=%b want 00/00", k, dout_b, changed_b);
                end
            end else if (dout_b !== 8'h37 || changed_b !== 2'b11 || err_b !== 2'b00) begin
                n_err++;
                $display("FAIL fast_commit: dout=%h changed=%b err=%b want 37/11/00", dout_b, changed_b, err_b);
            end
        end
        din_b = 8'hA7;
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_cmp++;
            if (k < 4) begin
                if (dout_b !== 8'h37 || changed_b !== 2'b00) begin
                    n_err++;
                    $display("FAIL fast_wait2 edge %0d: dout=%h changed=%b want 37/00", k, dout_b, changed_b);
                end
            end else if (dout_b !== 8'hA7 || changed_b !== 2'b10 || err_b !== 2'b10) begin
                n_err++;
                $display("FAIL fast_commit2: dout=%h changed=%b err=%b want A7/10/10", dout_b, changed_b, err_b);
            end
        end
        $display("test_fast done: dout_b=%h err_b=%b", dout_b, err_b);
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_hold();
        test_range();
        test_glitch();
        test_reset_mid();
        test_fast();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_lines_debounced
